// File: rtl/id_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
//
// Purpose:
//    Shared definitions for the IF->ID fetch queue. These are the default
//    payload width, the payload record carried by every queue entry, and a
//    constant-friendly ceiling-log2 helper used to size pointers and the
//    occupancy counter.
//
// Contents:
//    DW             default width of each payload field (next_pc, pc, ins)
//    fetch_entry_t  payload record {next_pc, pc, ins} at the default width
//    clog2()        ceiling log2, usable in localparam expressions
// ---------------------------------------------------------------------------
package id_pkg;

    localparam int DW = 32;

    // One fetched instruction as it travels from IF to decode.
    typedef struct packed {
        logic [DW-1:0] next_pc;
        logic [DW-1:0] pc;
        logic [DW-1:0] ins;
    } fetch_entry_t;

    // Smallest n such that 2**n >= value. Returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/id_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// id_fetch_queue_if
//
// Purpose:
//    Bundles the fetch-side and decode-side handshake of the IF->ID queue,
//    together with the flush request and the occupancy status.
//
// Modports:
//    master  the pipeline around the queue. It drives in_valid, in_next_pc,
//            in_pc, in_ins, out_ready and flush. It observes in_allowin,
//            out_valid, out_next_pc, out_pc, out_ins, count and almost_full.
//    slave   the queue itself, which sees the same signals with the
//            directions reversed.
//
// Parameters:
//    DW     payload field width
//    CNT_W  occupancy counter width, clog2(DEPTH+1) of the attached queue
// ---------------------------------------------------------------------------
interface id_fetch_queue_if
    import id_pkg::*;
#(
    parameter int DW    = id_pkg::DW,
    parameter int CNT_W = 3
);

    // Fetch side
    logic             in_valid;
    logic             in_allowin;
    logic [DW-1:0]    in_next_pc;
    logic [DW-1:0]    in_pc;
    logic [DW-1:0]    in_ins;

    // Decode side
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_next_pc;
    logic [DW-1:0]    out_pc;
    logic [DW-1:0]    out_ins;

    // Control and status
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             almost_full;

    modport master (
        output in_valid,
        output in_next_pc,
        output in_pc,
        output in_ins,
        output out_ready,
        output flush,
        input  in_allowin,
        input  out_valid,
        input  out_next_pc,
        input  out_pc,
        input  out_ins,
        input  count,
        input  almost_full
    );

    modport slave (
        input  in_valid,
        input  in_next_pc,
        input  in_pc,
        input  in_ins,
        input  out_ready,
        input  flush,
        output in_allowin,
        output out_valid,
        output out_next_pc,
        output out_pc,
        output out_ins,
        output count,
        output almost_full
    );

endinterface

// File: rtl/id_fetch_queue_ring_ptr.sv
// ---------------------------------------------------------------------------
// ring_ptr
//
// Purpose:
//    Modulo-DEPTH index into the fetch queue ring. DEPTH is a power of two,
//    so the natural binary overflow of the register is the wrap-around.
//
// Ports:
//    clk    in   rising-edge clock
//    reset  in   synchronous active-high reset, returns ptr to 0
//    clr    in   synchronous clear (flush), returns ptr to 0
//    inc    in   advance ptr by one slot at the next edge
//    ptr    out  current slot index, clog2(DEPTH) bits
// ---------------------------------------------------------------------------
module ring_ptr
    import id_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    inc,
    output logic [clog2(DEPTH)-1:0] ptr
);

    localparam int PTR_W = clog2(DEPTH);

    logic [PTR_W-1:0] r_ptr;

    // Reset and clear both rewind the ring to slot 0. Otherwise the pointer
    // advances one slot per accepted transfer. Wrapping needs no special
    // case because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/id_fetch_queue.sv
// ---------------------------------------------------------------------------
// id_fetch_queue
//
// Purpose:
//    DEPTH-entry in-order ring buffer between the IF stage and decode. It
//    replaces the single IF->ID pipeline register, so fetch can keep
//    running while decode stalls. Each entry holds {next_pc, pc, ins}.
//
// Ports:
//    clk    in   rising-edge clock
//    reset  in   synchronous active-high reset. Empties the queue; the
//                storage array itself is not cleared.
//    bus    slave side of id_fetch_queue_if:
//             in_valid/in_allowin + in_{next_pc,pc,ins}   fetch handshake
//             out_valid/out_ready + out_{next_pc,pc,ins}  decode handshake
//             flush        drop every queued entry (wrong path)
//             count        current occupancy, 0..DEPTH
//             almost_full  count >= AF_LEVEL
//
// Parameters:
//    DEPTH     number of entries, power of two, 2..16
//    DW        width of each payload field
//    AF_LEVEL  occupancy at or above which almost_full is raised, 1..DEPTH
//
// Timing:
//    An entry pushed at edge t is visible on out_* in cycle t+1 at the
//    earliest. There is no combinational path from in_* to out_*.
//    in_allowin depends combinationally on out_ready, because a pop frees a
//    slot in the same cycle. The fetch side must not feed in_allowin back
//    into out_ready.
// ---------------------------------------------------------------------------
module id_fetch_queue
    import id_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DW       = id_pkg::DW,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic            clk,
    input  logic            reset,
    id_fetch_queue_if.slave bus
);

    localparam int CNT_W = clog2(DEPTH + 1);
    localparam int PTR_W = clog2(DEPTH);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);

    // Local payload record at this instance's DW. The package record is
    // fixed at the default width.
    typedef struct packed {
        logic [DW-1:0] next_pc;
        logic [DW-1:0] pc;
        logic [DW-1:0] ins;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_wrPtr;
    logic [PTR_W-1:0] w_rdPtr;
    logic             w_notEmpty;
    logic             w_outValid;
    logic             w_allowin;
    logic             w_push;
    logic             w_pop;
    entry_t           w_head;
    entry_t           w_inEntry;

    // Handshake decode. Flush hides the head from decode and cancels any
    // push in the same cycle. in_allowin stays high when full if decode is
    // popping, because that pop frees a slot at the same edge.
    always_comb begin
        w_notEmpty = (r_count != '0);
        w_outValid = w_notEmpty && !bus.flush;
        w_allowin  = (r_count < FULL_CNT) || (bus.out_ready && w_notEmpty);
        w_push     = bus.in_valid && w_allowin && !bus.flush;
        w_pop      = w_outValid && bus.out_ready;
    end

    // Write and read slot indices. Flush rewinds both to slot 0 together
    // with the count, so the ring restarts from a known origin.
    ring_ptr #(
        .DEPTH (DEPTH)
    ) u_wrPtr (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.flush),
        .inc   (w_push),
        .ptr   (w_wrPtr)
    );

    ring_ptr #(
        .DEPTH (DEPTH)
    ) u_rdPtr (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.flush),
        .inc   (w_pop),
        .ptr   (w_rdPtr)
    );

    // Pack the incoming fetch payload into one record.
    always_comb begin
        w_inEntry.next_pc = bus.in_next_pc;
        w_inEntry.pc      = bus.in_pc;
        w_inEntry.ins     = bus.in_ins;
    end

    // Storage is written only on an accepted push, so the head entry holds
    // steady while decode stalls. The array carries no reset. Occupancy
    // alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[w_wrPtr] <= w_inEntry;
        end
    end

    // Occupancy. Reset and flush both empty the queue. A push and a pop in
    // the same cycle cancel out, including at full and at one entry.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Head presentation. Outputs are forced to zero whenever decode is not
    // offered a valid entry, so stale storage never leaks downstream.
    always_comb begin
        w_head = r_mem[w_rdPtr];
        if (!w_outValid) begin
            w_head = '0;
        end
    end

    assign bus.in_allowin  = w_allowin;
    assign bus.out_valid   = w_outValid;
    assign bus.out_next_pc = w_head.next_pc;
    assign bus.out_pc      = w_head.pc;
    assign bus.out_ins     = w_head.ins;
    assign bus.count       = r_count;
    assign bus.almost_full = (r_count >= AF_CNT);

endmodule

// File: tb/tb_id_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_id_fetch_queue
//
// Purpose:
//    Self-checking bench for id_fetch_queue at DEPTH=4, DW=32, AF_LEVEL=3.
//    The bench has three phases:
//      1) a directed vector table covering reset, fill, refusal at full,
//         drain order, push/pop at full, flush, and reset mid-operation
//      2) a wrap-around stream with alternating out_ready
//      3) randomized traffic checked against a queue-based reference model
// ---------------------------------------------------------------------------
module tb_id_fetch_queue;
    import id_pkg::*;

    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = 3;
    localparam int CNT_W    = 3;

    logic clk;
    logic reset;

    int testsRun;
    int testsFailed;

    id_fetch_queue_if #(.DW(32), .CNT_W(CNT_W)) bus ();

    id_fetch_queue #(
        .DEPTH    (DEPTH),
        .DW       (32),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One directed step: the inputs, the outputs expected before the edge,
    // and the occupancy expected after the edge.
    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] pc;
        logic        outRdy;
        logic        fl;
        logic        chkPre;
        logic        expValid;
        logic        expAllow;
        logic [31:0] expPc;
        int          expCount;
    } vec_t;

    // The instruction word and next_pc are derived from pc so that every
    // field of an entry can be predicted from pc alone.
    function automatic logic [31:0] insOf(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic rst, input logic iv,
                                input logic [31:0] pc, input logic outRdy,
                                input logic fl, input logic chk,
                                input logic ev, input logic ea,
                                input logic [31:0] ep, input int ec);
        vec_t v;
        v.rst = rst; v.iv = iv; v.pc = pc; v.outRdy = outRdy; v.fl = fl;
        v.chkPre = chk; v.expValid = ev; v.expAllow = ea; v.expPc = ep;
        v.expCount = ec;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic iv,
                                 input logic [31:0] pc, input logic outRdy,
                                 input logic fl);
        reset          = rst;
        bus.in_valid   = iv;
        bus.in_pc      = pc;
        bus.in_next_pc = pc + 32'd4;
        bus.in_ins     = insOf(pc);
        bus.out_ready  = outRdy;
        bus.flush      = fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        testsRun = testsRun + 1;
        if (got !== exp) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    vec_t          vecs[$];
    fetch_entry_t  model[$];
    logic [31:0]   gotPcs[$];

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // ---------------- phase 1: directed vector table ----------------
        //                rst iv pc            rdy fl  chk vld alw pc           cnt
        vecs.push_back(mk(1, 0, 32'h0,        0, 0,  0, 0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  1, 0, 1, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'hBFC00000, 0, 0,  1, 0, 1, 32'h0,        1));
        vecs.push_back(mk(0, 1, 32'h04,       0, 0,  1, 1, 1, 32'hBFC00000, 2));
        vecs.push_back(mk(0, 1, 32'h08,       0, 0,  1, 1, 1, 32'hBFC00000, 3));
        vecs.push_back(mk(0, 1, 32'h0C,       0, 0,  1, 1, 1, 32'hBFC00000, 4));
        vecs.push_back(mk(0, 1, 32'h10,       0, 0,  1, 1, 0, 32'hBFC00000, 4));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0,  1, 1, 1, 32'hBFC00000, 3));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0,  1, 1, 1, 32'h04,       2));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0,  1, 1, 1, 32'h08,       1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0,  1, 1, 1, 32'h0C,       0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0,  1, 0, 1, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h100,      0, 0,  1, 0, 1, 32'h0,        1));
        vecs.push_back(mk(0, 1, 32'h104,      0, 0,  1, 1, 1, 32'h100,      2));
        vecs.push_back(mk(0, 1, 32'h108,      0, 0,  1, 1, 1, 32'h100,      3));
        vecs.push_back(mk(0, 1, 32'h10C,      0, 0,  1, 1, 1, 32'h100,      4));
        vecs.push_back(mk(0, 1, 32'h10,       1, 0,  1, 1, 1, 32'h100,      4));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0,  1, 1, 1, 32'h104,      3));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0,  1, 1, 1, 32'h108,      2));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0,  1, 1, 1, 32'h10C,      1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0,  1, 1, 1, 32'h10,       0));
        vecs.push_back(mk(0, 1, 32'h200,      0, 0,  1, 0, 1, 32'h0,        1));
        vecs.push_back(mk(0, 1, 32'h204,      0, 0,  1, 1, 1, 32'h200,      2));
        vecs.push_back(mk(0, 1, 32'h208,      0, 0,  1, 1, 1, 32'h200,      3));
        vecs.push_back(mk(0, 1, 32'h40,       0, 1,  1, 0, 1, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h80,       0, 0,  1, 0, 1, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  1, 1, 1, 32'h80,       1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0,  1, 1, 1, 32'h80,       0));
        vecs.push_back(mk(0, 1, 32'h300,      0, 0,  1, 0, 1, 32'h0,        1));
        vecs.push_back(mk(0, 1, 32'h304,      0, 0,  1, 1, 1, 32'h300,      2));
        vecs.push_back(mk(1, 1, 32'h308,      1, 0,  1, 1, 1, 32'h300,      0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0,  1, 0, 1, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h400,      0, 0,  1, 0, 1, 32'h0,        1));
        vecs.push_back(mk(1, 1, 32'h404,      0, 1,  1, 0, 1, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0,  1, 0, 1, 32'h0,        0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].iv, vecs[i].pc,
                          vecs[i].outRdy, vecs[i].fl);
            #1;
            if (vecs[i].chkPre) begin
                checkOutput($sformatf("vec%0d.out_valid", i),
                            32'(bus.out_valid), 32'(vecs[i].expValid));
                checkOutput($sformatf("vec%0d.in_allowin", i),
                            32'(bus.in_allowin), 32'(vecs[i].expAllow));
                checkOutput($sformatf("vec%0d.out_pc", i),
                            bus.out_pc, vecs[i].expPc);
                checkOutput($sformatf("vec%0d.out_next_pc", i),
                            bus.out_next_pc,
                            vecs[i].expValid ? vecs[i].expPc + 32'd4 : 32'h0);
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d.count", i),
                        32'(bus.count), 32'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d.almost_full", i),
                        32'(bus.almost_full),
                        32'(vecs[i].expCount >= AF_LEVEL));
        end

        // ---------------- phase 2: wrap-around stream ----------------
        begin
            int sent;
            int cycles;
            logic accepted;
            sent   = 0;
            cycles = 0;
            gotPcs.delete();
            while (gotPcs.size() < 10 && cycles < 200) begin
                applyStimulus(1'b0, sent < 10, 32'h1000 + 32'(sent) * 32'd4,
                              cycles[0], 1'b0);
                #1;
                accepted = bus.in_valid && bus.in_allowin;
                if (bus.out_valid && bus.out_ready) begin
                    gotPcs.push_back(bus.out_pc);
                end
                @(posedge clk);
                #1;
                if (accepted) sent = sent + 1;
                checkOutput("wrap.countBound", 32'(bus.count <= 3'(DEPTH)), 32'd1);
                cycles = cycles + 1;
            end
            checkOutput("wrap.delivered", 32'(gotPcs.size()), 32'd10);
            for (int k = 0; k < 10; k++) begin
                if (k < gotPcs.size()) begin
                    checkOutput($sformatf("wrap.pc%0d", k), gotPcs[k],
                                32'h1000 + 32'(k) * 32'd4);
                end
            end
        end

        // ---------------- phase 3: randomized vs reference model ----------------
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        model.delete();
        for (int c = 0; c < 600; c++) begin
            logic rst, iv, rdy, fl;
            logic [31:0] pc;
            logic expValid, expAllow, doPush, doPop;
            fetch_entry_t head, e;
            // Alternate between producer-heavy and consumer-heavy phases so
            // that both full and empty are visited often.
            rst = ($urandom_range(0, 79) == 0);
            fl  = ($urandom_range(0, 24) == 0);
            if (((c / 40) % 2) == 0) begin
                iv  = ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 3) == 0);
            end else begin
                iv  = ($urandom_range(0, 3) == 0);
                rdy = ($urandom_range(0, 3) != 0);
            end
            pc = $urandom;
            applyStimulus(rst, iv, pc, rdy, fl);

            expValid = (model.size() != 0) && !fl;
            expAllow = (model.size() < DEPTH) || (rdy && model.size() != 0);
            head     = '0;
            if (expValid) head = model[0];
            #1;
            checkOutput("rand.out_valid", 32'(bus.out_valid), 32'(expValid));
            checkOutput("rand.in_allowin", 32'(bus.in_allowin), 32'(expAllow));
            checkOutput("rand.out_pc", bus.out_pc, head.pc);
            checkOutput("rand.out_next_pc", bus.out_next_pc, head.next_pc);
            checkOutput("rand.out_ins", bus.out_ins, head.ins);

            doPush = iv && expAllow && !fl;
            doPop  = expValid && rdy;
            @(posedge clk);
            #1;
            if (rst || fl) begin
                model.delete();
            end else begin
                if (doPop) void'(model.pop_front());
                if (doPush) begin
                    e.next_pc = pc + 32'd4;
                    e.pc      = pc;
                    e.ins     = insOf(pc);
                    model.push_back(e);
                end
            end
            checkOutput("rand.count", 32'(bus.count), 32'(model.size()));
            checkOutput("rand.almost_full", 32'(bus.almost_full),
                        32'(model.size() >= AF_LEVEL));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/id_fetch_queue.md
Name: id_fetch_queue

Overview:
- Parametrised instruction buffer that sits between the IF stage and the decode stage. It replaces the single-entry IF→ID register with a DEPTH-entry in-order ring buffer.
- Each entry carries {next_pc, pc, ins}.
- Uses the valid/allowin handshake on both sides, so IF can run ahead while decode stalls.
- Provides a synchronous flush for wrong-path entries, an occupancy count and an almost-full indication.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- DW, 32, width of each payload field (next_pc, pc, ins).
- AF_LEVEL, DEPTH-1, occupancy at or above which almost_full is asserted; range 1..DEPTH.
- CNT_W, clog2(DEPTH+1), width of count (localparam, derived).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  IF has an instruction to deliver (IF_to_ID_valid).
- in_allowin  out  1  queue accepts in_* this cycle.
- in_next_pc  in  DW  PC+4 of the delivered instruction.
- in_pc  in  DW  PC of the delivered instruction.
- in_ins  in  DW  instruction word.
- out_valid  out  1  head entry valid toward decode.
- out_ready  in  1  decode consumes head this cycle (ready_go && EX_allowin).
- out_next_pc  out  DW  head next_pc.
- out_pc  out  DW  head pc.
- out_ins  out  DW  head instruction.
- flush  in  1  discard all entries (branch redirect / wrong path).
- count  out  CNT_W  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_LEVEL.

Behaviour:
- Reset (clk edge with reset=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Hence out_valid=0, almost_full=0, in_allowin=1, out_* = 0.
  - Storage array is not reset.
- Combinational outputs:
  - out_valid = (count!=0) && !flush.
  - out_* = storage[rd_ptr] when out_valid, else 0.
  - in_allowin = (count<DEPTH) || (out_ready && count!=0). A pop frees a slot in the same cycle. in_allowin is combinational on out_ready; IF must not feed it back into out_ready.
- Push: push = in_valid && in_allowin && !flush.
  - Writes storage[wr_ptr].
  - wr_ptr <= (wr_ptr+1) mod DEPTH.
- Pop: pop = out_valid && out_ready.
  - rd_ptr <= (rd_ptr+1) mod DEPTH.
- Count update:
  - count <= count + push - pop.
  - Push and pop together leave count unchanged, including at count=DEPTH and at count=1.
  - Pointers wrap naturally because DEPTH is a power of two.
- Latency:
  - An entry pushed at edge t appears on out_* after edge t. It is visible to decode in cycle t+1 at the earliest.
  - There is no combinational bypass from in_* to out_*.
- Empty with push: out_valid rises the next cycle.
- Full (count=DEPTH) with out_ready=0: in_allowin=0 and the push is refused. IF holds its data.
- Flush (takes priority over push and pop):
  - Next edge: wr_ptr=rd_ptr=0, count=0.
  - The push presented in the flush cycle is dropped.
  - out_valid=0 during the flush cycle, so decode sees no head.
- Reset and flush together: same result as reset.
- Reset mid-operation: all entries are discarded and nothing is delivered afterwards.
- almost_full is derived from the registered count (combinational compare). It changes only after an edge.
- Storage is written only on push, and head data stays stable while out_valid && !out_ready.

Decomposition:
- Shared package id_pkg holds:
  - the payload typedef fetch_entry_t {next_pc, pc, ins} of width DW;
  - a clog2 function;
  - default DW=32.
- Sub-module ring_ptr (parameter DEPTH; inputs clk, reset, clr, inc; output ptr) is instantiated twice, for wr_ptr and rd_ptr.
- Storage array, count and handshake logic stay in id_fetch_queue.

Test Plan:
- Reset, then idle: after reset, count=0, out_valid=0, in_allowin=1, out_pc=0.
- Fill, DEPTH=4:
  - Push pc=0xBFC00000, 0x04, 0x08, 0x0C with out_ready=0.
  - After the 4th edge: count=4, in_allowin=0, almost_full=1.
  - A 5th push pc=0x10 is refused and count stays 4.
- Drain order: from full, set out_ready=1 for 4 cycles.
  - out_pc sequence is 0xBFC00000, 0x04, 0x08, 0x0C.
  - Then count=0, out_valid=0.
- Simultaneous push/pop at full:
  - count=4, out_ready=1, in_valid=1 with pc=0x10.
  - in_allowin=1 and count stays 4.
  - Head advances, and 0x10 appears after the three older entries.
- Wrap-around: stream 10 instructions with alternating out_ready.
  - All pcs come out in order with no loss or duplication.
  - count never exceeds 4.
- Flush:
  - With count=3 and in_valid=1 (pc=0x40), assert flush for 1 cycle.
  - out_valid=0 in that cycle; next cycle count=0.
  - A following push of pc=0x80 becomes the head after one edge.
